// File: rtl/axi_lite_uart_arbiter.sv
// Round-robin AXI-Lite master: grants one of P_NUM_REQ requesters, runs a single
// register access against the UART slave port and pulses the response back to it.
module axi_lite_uart_arbiter #(
   parameter int unsigned P_NUM_REQ          = 2,
   parameter int unsigned P_S_AXI_ADDR_WIDTH = 16,
   parameter int unsigned P_S_AXI_DATA_WIDTH = 32
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [P_NUM_REQ-1:0]                    req_valid,
   output logic [P_NUM_REQ-1:0]                    req_ready,
   input  logic [P_NUM_REQ-1:0]                    req_write,
   input  logic [P_NUM_REQ*P_S_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [P_NUM_REQ*P_S_AXI_DATA_WIDTH-1:0] req_wdata,
   output logic [P_NUM_REQ-1:0]                    rsp_valid,
   output logic [1:0]                              rsp_resp,
   output logic [P_S_AXI_DATA_WIDTH-1:0]           rsp_rdata,
   output logic [P_S_AXI_ADDR_WIDTH-1:0]           m_axi_awaddr,
   output logic                                    m_axi_awvalid,
   input  logic                                    m_axi_awready,
   output logic [P_S_AXI_DATA_WIDTH-1:0]           m_axi_wdata,
   output logic                                    m_axi_wvalid,
   input  logic                                    m_axi_wready,
   input  logic [1:0]                              m_axi_bresp,
   input  logic                                    m_axi_bvalid,
   output logic                                    m_axi_bready,
   output logic [P_S_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
   output logic                                    m_axi_arvalid,
   input  logic                                    m_axi_arready,
   input  logic [P_S_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
   input  logic [1:0]                              m_axi_rresp,
   input  logic                                    m_axi_rvalid,
   output logic                                    m_axi_rready
);

   localparam int unsigned PTR_W = $clog2(P_NUM_REQ);

   typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RRESP, S_DONE} state_e;

   state_e                          state_q, state_d;
   logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]                gnt_q, gnt_d;
   logic [PTR_W-1:0]                pick, cand;
   logic                            pick_vld;
   logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                            arvalid_q, arvalid_d, rready_q, rready_d;
   logic [P_S_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [P_S_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [P_NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
   logic [1:0]                      rsp_resp_q, rsp_resp_d;
   logic [P_S_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

   // First valid requester at or above rr_ptr, wrapping
   always_comb begin
      pick     = rr_ptr_q;
      pick_vld = 1'b0;
      cand     = '0;
      for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
         cand = PTR_W'((32'(rr_ptr_q) + i) % P_NUM_REQ);
         if (!pick_vld && req_valid[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // Gated by reset so nothing is offered while the block is held in reset
   always_comb begin
      req_ready = '0;
      if (reset && state_q == S_IDLE && pick_vld) req_ready[pick] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_d    = pick;
               rr_ptr_d = (pick == PTR_W'(P_NUM_REQ - 1)) ? '0 : pick + 1'b1;
               if (req_write[pick]) begin
                  awaddr_d  = req_addr[32'(pick)*P_S_AXI_ADDR_WIDTH +: P_S_AXI_ADDR_WIDTH];
                  wdata_d   = req_wdata[32'(pick)*P_S_AXI_DATA_WIDTH +: P_S_AXI_DATA_WIDTH];
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WADDR;
               end else begin
                  araddr_d  = req_addr[32'(pick)*P_S_AXI_ADDR_WIDTH +: P_S_AXI_ADDR_WIDTH];
                  arvalid_d = 1'b1;
                  state_d   = S_RADDR;
               end
            end
         end
         S_WADDR: begin
            // AW and W complete independently; a dropped valid marks its channel done
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
            if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
               bready_d = 1'b1;
               state_d  = S_WRESP;
            end
         end
         S_WRESP: begin
            if (m_axi_bvalid) begin
               bready_d           = 1'b0;
               rsp_resp_d         = m_axi_bresp;
               rsp_rdata_d        = '0;
               rsp_valid_d        = '0;
               rsp_valid_d[gnt_q] = 1'b1;
               state_d            = S_DONE;
            end
         end
         S_RADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RRESP;
            end
         end
         S_RRESP: begin
            if (m_axi_rvalid) begin
               rready_d           = 1'b0;
               rsp_resp_d         = m_axi_rresp;
               rsp_rdata_d        = m_axi_rdata;
               rsp_valid_d        = '0;
               rsp_valid_d[gnt_q] = 1'b1;
               state_d            = S_DONE;
            end
         end
         S_DONE: begin
            rsp_valid_d = '0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= '0;
         rsp_resp_q  <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_axi_lite_uart_arbiter.sv
// Bench for axi_lite_uart_arbiter: transaction-level model predicts per-cycle outputs
// from grant order and slave delays; a scheduled slave model answers the AXI port.
module tb_axi_lite_uart_arbiter;

   localparam int unsigned NREQ = 2;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid, req_ready, req_write, rsp_valid;
   logic [NREQ*16-1:0]   req_addr;
   logic [NREQ*32-1:0]   req_wdata;
   logic [1:0]           rsp_resp;
   logic [31:0]          rsp_rdata;
   logic [15:0]          m_axi_awaddr, m_axi_araddr;
   logic [31:0]          m_axi_wdata, m_axi_rdata;
   logic                 m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic                 m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic                 m_axi_rvalid, m_axi_rready;
   logic [1:0]           m_axi_bresp, m_axi_rresp;

   logic [15:0]          rq_addr  [NREQ];
   logic [31:0]          rq_wdata [NREQ];
   assign req_addr  = {rq_addr[1], rq_addr[0]};
   assign req_wdata = {rq_wdata[1], rq_wdata[0]};

   axi_lite_uart_arbiter #(
      .P_NUM_REQ(NREQ), .P_S_AXI_ADDR_WIDTH(16), .P_S_AXI_DATA_WIDTH(32)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic int unsigned umax(input int unsigned x, input int unsigned y);
      return (x > y) ? x : y;
   endfunction

   // One transaction: accept cycle, requester, access, slave delays and the
   // cycle h in which the response handshake completes.
   typedef struct {
      int unsigned a;
      int unsigned g;
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int unsigned da, dw, bd;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int unsigned h;
   } txn_t;

   int unsigned cfg_da, cfg_dw, cfg_bd;
   logic [1:0]  cfg_resp;
   logic [31:0] cfg_rdata;

   txn_t        t;
   bit          busy = 1'b0;
   int unsigned rr = 0;
   int unsigned n_acc = 0;
   int unsigned last_acc = 0;
   int unsigned glog[$];
   int unsigned dlog[$];
   int unsigned gi;
   bit          found;
   logic [NREQ-1:0] e_ready, e_rsp;
   bit          e_aw, e_w, e_b, e_ar, e_r;

   // Model and per-cycle compare
   always @(negedge clock) begin
      if (!reset) begin
         busy = 1'b0;
         rr   = 0;
         chk("rst_req_ready", 64'(req_ready), 64'(0));
         chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'(0));
         chk("rst_addr", 64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
         chk("rst_wdata", 64'(m_axi_wdata), 64'(0));
         chk("rst_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'(0));
      end else if (busy) begin
         chk("busy_req_ready", 64'(req_ready), 64'(0));
         e_aw = 1'b0; e_w = 1'b0; e_b = 1'b0; e_ar = 1'b0; e_r = 1'b0;
         if (t.wr) begin
            e_aw = (cyc >= t.a + 1) && (cyc <= t.a + 1 + t.da);
            e_w  = (cyc >= t.a + 1) && (cyc <= t.a + 1 + t.dw);
            e_b  = (cyc >= t.a + 2 + umax(t.da, t.dw)) && (cyc <= t.h);
         end else begin
            e_ar = (cyc >= t.a + 1) && (cyc <= t.a + 1 + t.da);
            e_r  = (cyc >= t.a + 2 + t.da) && (cyc <= t.h);
         end
         chk("awvalid", 64'(m_axi_awvalid), 64'(e_aw));
         chk("wvalid",  64'(m_axi_wvalid),  64'(e_w));
         chk("bready",  64'(m_axi_bready),  64'(e_b));
         chk("arvalid", 64'(m_axi_arvalid), 64'(e_ar));
         chk("rready",  64'(m_axi_rready),  64'(e_r));
         if (e_aw) chk("awaddr", 64'(m_axi_awaddr), 64'(t.addr));
         if (e_w)  chk("wdata",  64'(m_axi_wdata),  64'(t.wdata));
         if (e_ar) chk("araddr", 64'(m_axi_araddr), 64'(t.addr));
         e_rsp = '0;
         if (cyc == t.h + 1) e_rsp[t.g] = 1'b1;
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
         if (cyc == t.h + 1) begin
            chk("rsp_resp",  64'(rsp_resp),  64'(t.resp));
            chk("rsp_rdata", 64'(rsp_rdata), t.wr ? 64'(0) : 64'(t.rdata));
            busy = 1'b0;
         end
      end else begin
         e_ready = '0;
         found   = 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            gi = (rr + k) % NREQ;
            if (!found && req_valid[gi]) begin
               found = 1'b1;
               e_ready[gi] = 1'b1;
            end
         end
         chk("req_ready", 64'(req_ready), 64'(e_ready));
         chk("idle_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'(0));
         chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
         if (found) begin
            t.g     = e_ready[1] ? 1 : 0;
            t.a     = cyc;
            t.wr    = req_write[t.g];
            t.addr  = rq_addr[t.g];
            t.wdata = rq_wdata[t.g];
            t.da    = cfg_da;
            t.dw    = cfg_dw;
            t.bd    = cfg_bd;
            t.resp  = cfg_resp;
            t.rdata = cfg_rdata;
            t.h     = t.wr ? umax(t.a + 2 + umax(t.da, t.dw), t.a + 1 + t.bd)
                           : umax(t.a + 2 + t.da, t.a + 1 + t.bd);
            busy     = 1'b1;
            rr       = (t.g + 1) % NREQ;
            n_acc    = n_acc + 1;
            last_acc = cyc;
            glog.push_back(t.g);
         end
      end
   end

   // Grant order as actually offered by the DUT
   always @(negedge clock) begin
      if (reset && |(req_ready & req_valid)) dlog.push_back(req_ready[1] ? 1 : 0);
   end

   // Slave: handshakes scheduled from the active transaction's delays
   always @(posedge clock) begin
      #1;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      if (busy && reset) begin
         if (t.wr) begin
            m_axi_awready = (cyc == t.a + 1 + t.da);
            m_axi_wready  = (cyc == t.a + 1 + t.dw);
            if (cyc >= t.a + 1 + t.bd && cyc <= t.h) begin
               m_axi_bvalid = 1'b1;
               m_axi_bresp  = t.resp;
            end
         end else begin
            m_axi_arready = (cyc == t.a + 1 + t.da);
            if (cyc >= t.a + 1 + t.bd && cyc <= t.h) begin
               m_axi_rvalid = 1'b1;
               m_axi_rresp  = t.resp;
               m_axi_rdata  = t.rdata;
            end
         end
      end
   end

   task automatic cfg(input int unsigned da, input int unsigned dw, input int unsigned bd,
                      input logic [1:0] resp, input logic [31:0] rd);
      cfg_da = da; cfg_dw = dw; cfg_bd = bd; cfg_resp = resp; cfg_rdata = rd;
   endtask

   task automatic issue(input int r, input bit wr, input logic [15:0] ad, input logic [31:0] wd);
      req_write[r] = wr;
      rq_addr[r]   = ad;
      rq_wdata[r]  = wd;
      req_valid[r] = 1'b1;
   endtask

   task automatic wait_acc(input int unsigned n);
      int unsigned guard = 0;
      while (n_acc < n && guard < 500) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("grant_wait", 64'(n_acc >= n), 64'(1));
   endtask

   task automatic wait_idle();
      int unsigned guard = 0;
      while (busy && guard < 500) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("idle_wait", 64'(busy), 64'(0));
   endtask

   task automatic at_cyc(input int unsigned c);
      int unsigned guard = 0;
      while (cyc < c && guard < 500) begin
         @(posedge clock); #1;
         guard++;
      end
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a;
      int unsigned base;
      req_valid = '0; req_write = '0;
      rq_addr[0] = '0; rq_addr[1] = '0; rq_wdata[0] = '0; rq_wdata[1] = '0;
      cfg(0, 0, 1, 2'b00, 32'h0);
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      // Zero-wait write from requester 0
      issue(0, 1'b1, 16'h0004, 32'h0000_0041);
      wait_acc(1);
      req_valid[0] = 1'b0;
      a = last_acc;
      at_cyc(a + 1);
      chk("t1_awvalid", 64'(m_axi_awvalid), 64'(1));
      chk("t1_awaddr", 64'(m_axi_awaddr), 64'h0004);
      chk("t1_wdata", 64'(m_axi_wdata), 64'h41);
      at_cyc(a + 3);
      chk("t1_rsp_valid", 64'(rsp_valid), 64'b01);
      chk("t1_rsp_resp", 64'(rsp_resp), 64'(0));
      wait_idle();

      // Zero-wait read from requester 1
      cfg(0, 0, 1, 2'b00, 32'h0000_005A);
      issue(1, 1'b0, 16'h0000, 32'h0);
      wait_acc(2);
      req_valid[1] = 1'b0;
      a = last_acc;
      at_cyc(a + 3);
      chk("t2_rsp_valid", 64'(rsp_valid), 64'b10);
      chk("t2_rsp_rdata", 64'(rsp_rdata), 64'h5A);
      chk("t2_rsp_resp", 64'(rsp_resp), 64'(0));
      wait_idle();

      // Contention from reset: both held for four transactions
      reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      glog.delete();
      dlog.delete();
      cfg(0, 0, 1, 2'b00, 32'h0);
      base = n_acc;
      issue(0, 1'b1, 16'h0008, 32'h0000_0100);
      issue(1, 1'b1, 16'h000C, 32'h0000_0200);
      wait_acc(base + 4);
      req_valid = '0;
      wait_idle();
      chk("t3_dut_count", 64'(dlog.size()), 64'(4));
      chk("t3_model_count", 64'(glog.size()), 64'(4));
      if (dlog.size() == 4) begin
         chk("t3_dut_order0", 64'(dlog[0]), 64'(0));
         chk("t3_dut_order1", 64'(dlog[1]), 64'(1));
         chk("t3_dut_order2", 64'(dlog[2]), 64'(0));
         chk("t3_dut_order3", 64'(dlog[3]), 64'(1));
      end
      if (glog.size() == 4) begin
         chk("t3_model_order1", 64'(glog[1]), 64'(1));
         chk("t3_model_order2", 64'(glog[2]), 64'(0));
      end

      // Split write handshake: AW immediate, W three cycles later
      cfg(0, 3, 1, 2'b00, 32'h0);
      issue(0, 1'b1, 16'h0010, 32'h0000_0055);
      wait_acc(n_acc + 1);
      req_valid[0] = 1'b0;
      a = last_acc;
      at_cyc(a + 2);
      chk("t4_awvalid_low", 64'(m_axi_awvalid), 64'(0));
      chk("t4_wvalid_high", 64'(m_axi_wvalid), 64'(1));
      at_cyc(a + 5);
      chk("t4_wvalid_low", 64'(m_axi_wvalid), 64'(0));
      chk("t4_bready_high", 64'(m_axi_bready), 64'(1));
      wait_idle();

      // SLVERR write with bvalid raised before bready, AW delayed one cycle
      cfg(1, 0, 0, 2'b10, 32'h0);
      issue(0, 1'b1, 16'h0014, 32'h0000_0077);
      wait_acc(n_acc + 1);
      req_valid[0] = 1'b0;
      a = last_acc;
      at_cyc(a + 4);
      chk("t5_rsp_valid", 64'(rsp_valid), 64'b01);
      chk("t5_rsp_resp", 64'(rsp_resp), 64'b10);
      wait_idle();

      // Following read proceeds: DECERR, rvalid early, AR delayed two cycles
      cfg(2, 0, 0, 2'b11, 32'hDEAD_BEEF);
      issue(1, 1'b0, 16'h0020, 32'h0);
      wait_acc(n_acc + 1);
      req_valid[1] = 1'b0;
      a = last_acc;
      at_cyc(a + 5);
      chk("t5_rd_rsp_valid", 64'(rsp_valid), 64'b10);
      chk("t5_rd_rsp_resp", 64'(rsp_resp), 64'b11);
      chk("t5_rd_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
      wait_idle();

      // Reset while waiting for BVALID
      cfg(0, 0, 5, 2'b00, 32'h0);
      issue(0, 1'b1, 16'h0018, 32'h0000_0099);
      wait_acc(n_acc + 1);
      req_valid[0] = 1'b0;
      a = last_acc;
      at_cyc(a + 2);
      chk("t6_in_wresp", 64'(m_axi_bready), 64'(1));
      @(posedge clock); #1;
      reset = 1'b0;
      cfg(0, 0, 1, 2'b00, 32'h0000_0033);
      issue(0, 1'b0, 16'h0030, 32'h0);
      issue(1, 1'b0, 16'h0034, 32'h0);
      @(negedge clock);
      chk("t6_rst_bready", 64'(m_axi_bready), 64'(0));
      chk("t6_rst_awaddr", 64'(m_axi_awaddr), 64'(0));
      chk("t6_rst_wdata", 64'(m_axi_wdata), 64'(0));
      chk("t6_rst_req_ready", 64'(req_ready), 64'(0));
      @(posedge clock); #1;
      reset = 1'b1;
      base = n_acc;
      @(negedge clock);
      chk("t6_first_grant", 64'(req_ready), 64'b01);
      @(posedge clock); #1;
      req_valid[0] = 1'b0;
      wait_acc(base + 2);
      req_valid[1] = 1'b0;
      wait_idle();
      repeat (3) @(posedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
